// File: rtl/rv32_div_unit.sv
// RV32M iterative divider: radix-2 restoring, one quotient bit per cycle.
// DIV/DIVU/REM/REMU with ISA-defined divide-by-zero and overflow results.
module rv32_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      div_op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] div_result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG =
    {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]   cnt_q;
  logic            rem_sel_q;
  logic            qneg_q;
  logic            rneg_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dvs_q;
  logic [XLEN-1:0] res_q;

  logic            is_signed;
  logic            s1_neg;
  logic            s2_neg;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic            by_zero;
  logic            ovf;
  logic            accept;
  logic            last;

  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic [XLEN-1:0] rem_n;
  logic [XLEN-1:0] quo_n;
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;
  logic [XLEN-1:0] fin;

  assign is_signed = ~div_op[0];
  assign s1_neg    = is_signed & src1[XLEN-1];
  assign s2_neg    = is_signed & src2[XLEN-1];
  assign a_abs     = s1_neg ? -src1 : src1;
  assign b_abs     = s2_neg ? -src2 : src2;
  assign by_zero   = (src2 == '0);
  assign ovf       = is_signed && (src1 == MIN_NEG)
                     && (src2 == '1);
  assign accept    = in_valid && (state_q == IDLE) && !flush;
  assign last      = (cnt_q == CW'(XLEN-1));

  // Trial subtract; bit XLEN of diff is the borrow.
  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign rem_n   = diff[XLEN] ? shifted[XLEN-1:0]
                              : diff[XLEN-1:0];
  assign quo_n   = {quo_q[XLEN-2:0], ~diff[XLEN]};
  assign q_fix   = qneg_q ? -quo_n : quo_n;
  assign r_fix   = rneg_q ? -rem_n : rem_n;
  assign fin     = rem_sel_q ? r_fix : q_fix;

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign div_result = res_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept)
          state_d = (by_zero || ovf) ? DONE : CALC;
      end
      CALC: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      rem_sel_q <= 1'b0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      res_q     <= '0;
    end else if (!flush) begin
      if (accept) begin
        cnt_q     <= '0;
        rem_sel_q <= div_op[1];
        qneg_q    <= s1_neg ^ s2_neg;
        rneg_q    <= s1_neg;
        rem_q     <= '0;
        quo_q     <= a_abs;
        dvs_q     <= b_abs;
        if (by_zero)
          res_q <= div_op[1] ? src1 : '1;
        else if (ovf)
          res_q <= div_op[1] ? '0 : MIN_NEG;
      end else if (state_q == CALC) begin
        rem_q <= rem_n;
        quo_q <= quo_n;
        cnt_q <= cnt_q + 1'b1;
        if (last) res_q <= fin;
      end
    end
  end

endmodule
